// File: rtl/pll_mon_pkg.sv
// Shared encodings and helpers for the PLL lock monitor.
// The 2-bit state encoding is visible on the state output port.
package pll_mon_pkg;

  localparam logic [1:0] ST_WAIT   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;
  localparam logic [1:0] ST_LOST   = 2'd3;

  function automatic int unsigned sat_inc(input int unsigned val,
                                          input int unsigned inc,
                                          input int unsigned max_val);
    int unsigned sum;
    sum = val + inc;
    return (sum > max_val) ? max_val : sum;
  endfunction

endpackage

// File: rtl/pll_mon_edge_cnt.sv
// One monitored clock: 3-flop synchronizer, rise detect and a saturating edge counter.
// count_now already includes an edge detected in the current cycle.
module pll_mon_edge_cnt
  import pll_mon_pkg::*;
#(
  parameter int CNT_W = 12
) (
  input  logic             clk_tb,
  input  logic             rst_n,
  input  logic             clk_in,
  input  logic             clear,
  input  logic             restart,
  output logic [CNT_W-1:0] count_now
);

  logic [2:0]       sync;
  logic             rise;
  logic [CNT_W-1:0] cnt;

  assign rise      = sync[1] & ~sync[2];
  assign count_now = (rise && (cnt != '1)) ? cnt + CNT_W'(1) : cnt;

  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      cnt  <= '0;
    end else begin
      sync <= {sync[1:0], clk_in};
      // the terminal-cycle edge is reported in meas_cnt, so the next window starts empty
      if (clear || restart) cnt <= '0;
      else                  cnt <= count_now;
    end
  end

endmodule

// File: rtl/pll_lock_monitor.sv
// PLL lock FSM plus per-clock edge-count window checker with saturating error counters.
//   state   | meaning
//   WAIT    | no lock seen since reset
//   SETTLE  | synced lock high, counting consecutive cycles
//   LOCKED  | lock stable; frequency windows run when chk_en
//   LOST    | lock dropped after having been LOCKED
module pll_lock_monitor
  import pll_mon_pkg::*;
#(
  parameter int N_CH       = 5,
  parameter int CNT_W      = 12,
  parameter int WINDOW     = 1000,
  parameter int TOL        = 2,
  parameter int SETTLE_CYC = 64,
  parameter int ERR_W      = 3
) (
  input  logic                  clk_tb,
  input  logic                  rst_n,
  input  logic                  pll_lock,
  input  logic [N_CH-1:0]       clk_mon,
  input  logic [N_CH*CNT_W-1:0] exp_cnt,
  input  logic                  chk_en,
  input  logic                  clr,
  output logic [1:0]            state,
  output logic                  locked,
  output logic                  meas_valid,
  output logic [N_CH*CNT_W-1:0] meas_cnt,
  output logic [N_CH-1:0]       freq_err,
  output logic [ERR_W-1:0]      lock_loss_cnt,
  output logic [ERR_W-1:0]      err_cnt
);

  localparam int WIN_W = $clog2(WINDOW);
  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int unsigned ERR_MAX = (32'd1 << ERR_W) - 32'd1;
  localparam logic signed [CNT_W:0] TOL_S = (CNT_W + 1)'(TOL);

  logic [1:0]              lk_sync;
  logic                    lk;
  logic [SET_W-1:0]        settle_cnt;
  logic                    ever_locked;
  logic [WIN_W-1:0]        win_cnt;
  logic                    win_active, win_term, meas_fire, loss_evt, mism_evt;
  logic [N_CH*CNT_W-1:0]   cnt_now;
  logic [N_CH-1:0]         mism;
  logic signed [CNT_W:0]   diff [N_CH];

  assign lk         = lk_sync[1];
  assign locked     = (state == ST_LOCKED);
  assign win_active = locked && chk_en;
  assign win_term   = win_active && (win_cnt == WIN_W'(WINDOW - 1));
  assign meas_fire  = win_term && lk;
  assign loss_evt   = locked && !lk;
  assign mism_evt   = meas_fire && (|mism);

  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n) lk_sync <= '0;
    else        lk_sync <= {lk_sync[0], pll_lock};
  end

  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_WAIT;
      settle_cnt  <= '0;
      ever_locked <= 1'b0;
    end else begin
      case (state)
        ST_WAIT: if (lk) begin
          state      <= ST_SETTLE;
          settle_cnt <= '0;
        end
        ST_SETTLE: begin
          if (!lk) begin
            // once the PLL has locked, any later drop is reported as a loss state
            state      <= ever_locked ? ST_LOST : ST_WAIT;
            settle_cnt <= '0;
          end else if (settle_cnt == SET_W'(SETTLE_CYC - 1)) begin
            state       <= ST_LOCKED;
            ever_locked <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + SET_W'(1);
          end
        end
        ST_LOCKED: if (!lk) state <= ST_LOST;
        default: if (lk) begin
          state      <= ST_SETTLE;
          settle_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n)                      win_cnt <= '0;
    else if (!win_active || win_term) win_cnt <= '0;
    else                             win_cnt <= win_cnt + WIN_W'(1);
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    pll_mon_edge_cnt #(.CNT_W(CNT_W)) u_edge_cnt (
      .clk_tb    (clk_tb),
      .rst_n     (rst_n),
      .clk_in    (clk_mon[g]),
      .clear     (!win_active),
      .restart   (win_term),
      .count_now (cnt_now[g*CNT_W +: CNT_W])
    );
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      diff[i] = $signed({1'b0, cnt_now[i*CNT_W +: CNT_W]})
              - $signed({1'b0, exp_cnt[i*CNT_W +: CNT_W]});
      mism[i] = (diff[i] > TOL_S) || (diff[i] < -TOL_S);
    end
  end

  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n) begin
      meas_valid    <= 1'b0;
      meas_cnt      <= '0;
      freq_err      <= '0;
      lock_loss_cnt <= '0;
      err_cnt       <= '0;
    end else begin
      meas_valid <= meas_fire;
      if (meas_fire) meas_cnt <= cnt_now;
      if (clr) begin
        freq_err      <= '0;
        lock_loss_cnt <= '0;
        err_cnt       <= '0;
      end else begin
        if (meas_fire) freq_err <= freq_err | mism;
        if (loss_evt)
          lock_loss_cnt <= ERR_W'(sat_inc(32'(lock_loss_cnt), 32'd1, ERR_MAX));
        err_cnt <= ERR_W'(sat_inc(32'(err_cnt), 32'(loss_evt) + 32'(mism_evt), ERR_MAX));
      end
    end
  end

endmodule
